// File: rtl/fc_rd_ctrl_if.sv
// Bus bundle between the FC read controller, its word memory, and the FC layer.
// The master side is the controller; the slave side is the memory plus layer.
interface fc_rd_ctrl_if #(
  parameter int batch_size   = 1,
  parameter int feature_size = 3,
  parameter int bias_size    = 2,
  parameter int addr_width   = 16
) ();
  logic                                 mem_rd_en;
  logic [addr_width-1:0]                mem_addr;
  logic [31:0]                          mem_rdata;
  logic [batch_size*feature_size*32-1:0] data;
  logic [feature_size*bias_size*32-1:0]  weight;
  logic [bias_size*32-1:0]               bias;
  logic                                 data_en;
  logic                                 weight_en;
  logic                                 bias_en;
  logic                                 bias_rq;
  logic                                 result_valid;

  modport master (
    output mem_rd_en, mem_addr, data, weight, bias, data_en, weight_en, bias_en,
    input  mem_rdata, bias_rq, result_valid
  );

  modport slave (
    input  mem_rd_en, mem_addr, data, weight, bias, data_en, weight_en, bias_en,
    output mem_rdata, bias_rq, result_valid
  );
endinterface

// File: rtl/fc_rd_ctrl.sv
// Sequences one fully-connected layer pass: fetch data+weights, present them,
// then fetch the bias on request and hold it until the layer reports a result.
module fc_rd_ctrl #(
  parameter int batch_size   = 1,
  parameter int feature_size = 3,
  parameter int bias_size    = 2,
  parameter int addr_width   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [addr_width-1:0] data_base,
  input  logic [addr_width-1:0] weight_base,
  input  logic [addr_width-1:0] bias_base,
  output logic                  busy,
  output logic                  done,
  fc_rd_ctrl_if.master          bus
);

  localparam int ND   = batch_size * feature_size;
  localparam int NW   = feature_size * bias_size;
  localparam int NB   = bias_size;
  localparam int NDW  = ND + NW;
  localparam int MAXN = (NDW > NB) ? NDW : NB;
  localparam int CW   = $clog2(MAXN + 1);

  localparam logic [CW-1:0] ND_C    = CW'(ND);
  localparam logic [CW-1:0] LAST_DW = CW'(NDW - 1);
  localparam logic [CW-1:0] LAST_B  = CW'(NB - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_DW,
    PRESENT_DW,
    WAIT_RQ,
    LOAD_B,
    HOLD_B,
    FINISH
  } state_t;

  state_t state, state_nxt;

  logic [addr_width-1:0] data_base_q, weight_base_q, bias_base_q;
  logic                  rd_en_q, rd_en_nxt;
  logic [addr_width-1:0] addr_q, addr_nxt;
  logic [CW-1:0]         req_idx, req_idx_nxt;
  logic                  cap_vld;
  logic [CW-1:0]         cap_idx;
  logic [ND*32-1:0]      data_q;
  logic [NW*32-1:0]      weight_q;
  logic [NB*32-1:0]      bias_q;

  // Read issue runs ahead of capture by one cycle; the FSM advances on the
  // capture of the final word, not on the issue of the final read.
  always_comb begin
    state_nxt   = state;
    rd_en_nxt   = 1'b0;
    addr_nxt    = addr_q;
    req_idx_nxt = req_idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = LOAD_DW;
          rd_en_nxt   = 1'b1;
          addr_nxt    = data_base;
          req_idx_nxt = '0;
        end
      end
      LOAD_DW: begin
        if (rd_en_q && (req_idx != LAST_DW)) begin
          rd_en_nxt   = 1'b1;
          req_idx_nxt = req_idx + 1'b1;
          if (req_idx_nxt < ND_C)
            addr_nxt = data_base_q + addr_width'(req_idx_nxt);
          else
            addr_nxt = weight_base_q + addr_width'(req_idx_nxt - ND_C);
        end
        if (cap_vld && (cap_idx == LAST_DW))
          state_nxt = PRESENT_DW;
      end
      PRESENT_DW: state_nxt = WAIT_RQ;
      WAIT_RQ: begin
        if (bus.bias_rq) begin
          state_nxt   = LOAD_B;
          rd_en_nxt   = 1'b1;
          addr_nxt    = bias_base_q;
          req_idx_nxt = '0;
        end
      end
      LOAD_B: begin
        if (rd_en_q && (req_idx != LAST_B)) begin
          rd_en_nxt   = 1'b1;
          req_idx_nxt = req_idx + 1'b1;
          addr_nxt    = bias_base_q + addr_width'(req_idx_nxt);
        end
        if (cap_vld && (cap_idx == LAST_B))
          state_nxt = HOLD_B;
      end
      HOLD_B: begin
        if (bus.result_valid)
          state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_en_q       <= 1'b0;
      addr_q        <= '0;
      req_idx       <= '0;
      cap_vld       <= 1'b0;
      cap_idx       <= '0;
      data_base_q   <= '0;
      weight_base_q <= '0;
      bias_base_q   <= '0;
    end else begin
      state   <= state_nxt;
      rd_en_q <= rd_en_nxt;
      addr_q  <= addr_nxt;
      req_idx <= req_idx_nxt;
      cap_vld <= rd_en_q;
      cap_idx <= req_idx;
      if ((state == IDLE) && start) begin
        data_base_q   <= data_base;
        weight_base_q <= weight_base;
        bias_base_q   <= bias_base;
      end
    end
  end

  // Word index k of the fetch stream maps straight onto the flat packed slot k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      weight_q <= '0;
      bias_q   <= '0;
    end else if (cap_vld) begin
      if (state == LOAD_DW) begin
        for (int i = 0; i < ND; i++)
          if (cap_idx == CW'(i)) data_q[i*32 +: 32] <= bus.mem_rdata;
        for (int i = 0; i < NW; i++)
          if (cap_idx == CW'(ND + i)) weight_q[i*32 +: 32] <= bus.mem_rdata;
      end else if (state == LOAD_B) begin
        for (int i = 0; i < NB; i++)
          if (cap_idx == CW'(i)) bias_q[i*32 +: 32] <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.data      = data_q;
  assign bus.weight    = weight_q;
  assign bus.bias      = bias_q;
  assign bus.data_en   = (state == PRESENT_DW);
  assign bus.weight_en = (state == PRESENT_DW);
  assign bus.bias_en   = (state == HOLD_B);
  assign busy          = (state != IDLE);
  assign done          = (state == FINISH);

endmodule

// File: tb/tb_fc_rd_ctrl.sv
// Self-checking bench for fc_rd_ctrl: default-parameter instance plus a
// 2x2x3 instance, checked against a cycle-level model of one layer pass.
module tb_fc_rd_ctrl;

  localparam int AW  = 16;
  localparam int ND  = 3;
  localparam int NW  = 6;
  localparam int NB  = 2;
  localparam int ND2 = 4;
  localparam int NW2 = 6;
  localparam int NB2 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_start, b_start;
  logic [AW-1:0] a_db, a_wb, a_bb, b_db, b_wb, b_bb;
  logic          a_busy, a_done, b_busy, b_done;
  logic [31:0]   mem_key;

  int total = 0;
  int bad   = 0;

  fc_rd_ctrl_if #(.batch_size(1), .feature_size(3), .bias_size(2), .addr_width(AW)) abus ();
  fc_rd_ctrl_if #(.batch_size(2), .feature_size(2), .bias_size(3), .addr_width(AW)) bbus ();

  fc_rd_ctrl #(.batch_size(1), .feature_size(3), .bias_size(2), .addr_width(AW)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start),
    .data_base(a_db), .weight_base(a_wb), .bias_base(a_bb),
    .busy(a_busy), .done(a_done), .bus(abus.master)
  );

  fc_rd_ctrl #(.batch_size(2), .feature_size(2), .bias_size(3), .addr_width(AW)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .data_base(b_db), .weight_base(b_wb), .bias_base(b_bb),
    .busy(b_busy), .done(b_done), .bus(bbus.master)
  );

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a, input logic [31:0] key);
    return {16'h0000, a} ^ key;
  endfunction

  // Single-port memory: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    abus.mem_rdata <= abus.mem_rd_en ? mem_word(abus.mem_addr, mem_key) : 32'hDEADBEEF;
    bbus.mem_rdata <= bbus.mem_rd_en ? mem_word(bbus.mem_addr, mem_key) : 32'hDEADBEEF;
  end

  // Trace of DUT A per pass-relative cycle; ctl = {rd_en,data_en,weight_en,bias_en,done,busy}.
  logic          tr_rd [64];
  logic [AW-1:0] tr_ad [64];
  logic [5:0]    tr_ctl[64];
  logic          ex_rd [64];
  logic [AW-1:0] ex_ad [64];
  logic [5:0]    ex_ctl[64];
  logic [ND*32-1:0] ex_data;
  logic [NW*32-1:0] ex_weight;
  logic [NB*32-1:0] ex_bias;

  // Reference pass: start in cycle 0, bias_rq honoured in cycle rq, result_valid in rv.
  function automatic void build_expect(input logic [AW-1:0] db, wb, bb,
                                       input logic [31:0] key, input int rq, rv);
    for (int c = 0; c < 64; c++) begin
      ex_rd[c]  = 1'b0;
      ex_ad[c]  = '0;
      ex_ctl[c] = {1'b0, c == ND+NW+2, c == ND+NW+2, (c >= rq+NB+2) && (c <= rv),
                   c == rv+1, (c >= 1) && (c <= rv+1)};
    end
    for (int k = 0; k < ND; k++) begin
      ex_rd[1+k] = 1'b1; ex_ctl[1+k][5] = 1'b1; ex_ad[1+k] = db + AW'(k);
      ex_data[k*32 +: 32] = mem_word(db + AW'(k), key);
    end
    for (int m = 0; m < NW; m++) begin
      ex_rd[1+ND+m] = 1'b1; ex_ctl[1+ND+m][5] = 1'b1; ex_ad[1+ND+m] = wb + AW'(m);
      ex_weight[m*32 +: 32] = mem_word(wb + AW'(m), key);
    end
    for (int b = 0; b < NB; b++) begin
      ex_rd[rq+1+b] = 1'b1; ex_ctl[rq+1+b][5] = 1'b1; ex_ad[rq+1+b] = bb + AW'(b);
      ex_bias[b*32 +: 32] = mem_word(bb + AW'(b), key);
    end
  endfunction

  // Drives one pass on DUT A and records the trace; extra pulses land in other states.
  task automatic drive_pass(input logic [AW-1:0] db, wb, bb,
                            input int rq_c, rv_c, st2_c, rq2_c, rv2_c, ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      a_start = (c == 0) || (c == st2_c);
      if (c == 0) begin
        a_db = db; a_wb = wb; a_bb = bb;
      end else begin
        a_db = AW'($urandom); a_wb = AW'($urandom); a_bb = AW'($urandom);
      end
      abus.bias_rq      = (c == rq_c) || (c == rq2_c);
      abus.result_valid = (c == rv_c) || (c == rv2_c);
      @(negedge clk);
      tr_rd[c]  = abus.mem_rd_en;
      tr_ad[c]  = abus.mem_addr;
      tr_ctl[c] = {abus.mem_rd_en, abus.data_en, abus.weight_en, abus.bias_en, a_done, a_busy};
    end
    a_start = 1'b0; abus.bias_rq = 1'b0; abus.result_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total++;
    if ({abus.mem_rd_en, abus.mem_addr, abus.data, abus.weight, abus.bias, abus.data_en,
         abus.weight_en, abus.bias_en, a_busy, a_done} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_a got rd=%b addr=%h busy=%b done=%b exp all zero",
               abus.mem_rd_en, abus.mem_addr, a_busy, a_done);
    end
    total++;
    if ({bbus.mem_rd_en, bbus.mem_addr, bbus.data, bbus.weight, bbus.bias, b_busy, b_done} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_b got rd=%b busy=%b exp all zero", bbus.mem_rd_en, b_busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (a_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_after_reset got busy=%b exp 0", a_busy);
    end
  endtask

  task automatic test_nominal;
    mem_key = 32'h0;
    build_expect(16'h10, 16'h20, 16'h30, mem_key, 14, 25);
    drive_pass(16'h10, 16'h20, 16'h30, 14, 25, -1, -1, -1, 28);
    for (int c = 0; c < 28; c++) begin
      total++;
      if (tr_ctl[c] !== ex_ctl[c]) begin
        bad++;
        $display("[TB] FAIL nom_ctl@%0d got=%b exp=%b", c, tr_ctl[c], ex_ctl[c]);
      end
      if (ex_rd[c]) begin
        total++;
        if (tr_ad[c] !== ex_ad[c]) begin
          bad++;
          $display("[TB] FAIL nom_addr@%0d got=%h exp=%h", c, tr_ad[c], ex_ad[c]);
        end
      end
    end
    total++;
    if (abus.data !== {32'h12, 32'h11, 32'h10}) begin
      bad++;
      $display("[TB] FAIL nom_data got=%h exp=%h", abus.data, {32'h12, 32'h11, 32'h10});
    end
    total++;
    if (abus.weight[5*32 +: 32] !== 32'h25 || abus.weight[31:0] !== 32'h20) begin
      bad++;
      $display("[TB] FAIL nom_weight_corner got w21=%h w00=%h exp 25/20",
               abus.weight[5*32 +: 32], abus.weight[31:0]);
    end
    total++;
    if (abus.weight !== ex_weight || abus.bias !== ex_bias) begin
      bad++;
      $display("[TB] FAIL nom_wb got w=%h b=%h exp w=%h b=%h", abus.weight, abus.bias, ex_weight, ex_bias);
    end
  endtask

  task automatic test_ignored_inputs;
    logic [63:0] rd_got, rd_exp, dn_got, dn_exp;
    mem_key = 32'h0;
    build_expect(16'h10, 16'h20, 16'h30, mem_key, 14, 25);
    drive_pass(16'h10, 16'h20, 16'h30, 14, 25, 5, 6, 14 + NB + 1, 28);
    rd_got = '0; rd_exp = '0; dn_got = '0; dn_exp = '0;
    for (int c = 0; c < 28; c++) begin
      rd_got[c] = tr_rd[c]; rd_exp[c] = ex_rd[c];
      dn_got[c] = tr_ctl[c][1]; dn_exp[c] = ex_ctl[c][1];
    end
    total++;
    if (rd_got !== rd_exp) begin
      bad++;
      $display("[TB] FAIL ign_read_cycles got=%h exp=%h", rd_got, rd_exp);
    end
    total++;
    if (dn_got !== dn_exp) begin
      bad++;
      $display("[TB] FAIL ign_done_cycles got=%h exp=%h", dn_got, dn_exp);
    end
    total++;
    if (tr_ad[15] !== 16'h30 || tr_ad[16] !== 16'h31 || tr_ad[4] !== 16'h20) begin
      bad++;
      $display("[TB] FAIL ign_addr got a4=%h a15=%h a16=%h exp 20/30/31", tr_ad[4], tr_ad[15], tr_ad[16]);
    end
    total++;
    if (tr_ctl[18][2] !== 1'b1 || tr_ctl[25][2] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ign_bias_en got c18=%b c25=%b exp 1/1", tr_ctl[18][2], tr_ctl[25][2]);
    end
  endtask

  task automatic test_reset_mid;
    drive_pass(16'h10, 16'h20, 16'h30, -1, -1, -1, -1, -1, 7);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({abus.mem_rd_en, abus.mem_addr, abus.data, abus.weight, abus.bias, abus.data_en,
         abus.weight_en, abus.bias_en, a_busy, a_done} !== '0) begin
      bad++;
      $display("[TB] FAIL mid_reset got rd=%b addr=%h data=%h busy=%b exp all zero",
               abus.mem_rd_en, abus.mem_addr, abus.data, a_busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    mem_key = 32'h0;
    build_expect(16'h40, 16'h50, 16'h60, mem_key, 13, 20);
    drive_pass(16'h40, 16'h50, 16'h60, 13, 20, -1, -1, -1, 23);
    total++;
    if (abus.data !== {32'h42, 32'h41, 32'h40}) begin
      bad++;
      $display("[TB] FAIL mid_recover_data got=%h exp=%h", abus.data, {32'h42, 32'h41, 32'h40});
    end
    total++;
    if (abus.weight !== ex_weight || abus.bias !== ex_bias || tr_ctl[21] !== ex_ctl[21]
        || tr_ctl[22] !== ex_ctl[22]) begin
      bad++;
      $display("[TB] FAIL mid_recover_rest got b=%h c21=%b exp b=%h c21=%b",
               abus.bias, tr_ctl[21], ex_bias, ex_ctl[21]);
    end
  endtask

  task automatic test_back_to_back;
    int den_cnt, done_cnt, rq, rv;
    logic [AW-1:0] db, wb, bb;
    den_cnt = 0; done_cnt = 0;
    rq = ND + NW + 3;
    rv = rq + NB + 2;
    for (int p = 0; p < 2; p++) begin
      mem_key = $urandom;
      db = AW'($urandom); wb = AW'($urandom); bb = AW'($urandom);
      build_expect(db, wb, bb, mem_key, rq, rv);
      drive_pass(db, wb, bb, rq, rv, -1, -1, -1, rv + 2);
      for (int c = 0; c < rv + 2; c++) begin
        den_cnt  += int'(tr_ctl[c][4]);
        done_cnt += int'(tr_ctl[c][1]);
      end
      total++;
      if (abus.data !== ex_data || abus.weight !== ex_weight || abus.bias !== ex_bias) begin
        bad++;
        $display("[TB] FAIL b2b_contents pass=%0d got d=%h b=%h exp d=%h b=%h",
                 p, abus.data, abus.bias, ex_data, ex_bias);
      end
      total++;
      if (tr_rd[1] !== 1'b1 || tr_ad[1] !== db) begin
        bad++;
        $display("[TB] FAIL b2b_first_read pass=%0d got rd=%b addr=%h exp 1/%h", p, tr_rd[1], tr_ad[1], db);
      end
    end
    total++;
    if (den_cnt !== 2 || done_cnt !== 2) begin
      bad++;
      $display("[TB] FAIL b2b_counts got data_en=%0d done=%0d exp 2/2", den_cnt, done_cnt);
    end
  endtask

  task automatic test_random;
    int rq, rv, ncyc;
    logic [AW-1:0] db, wb, bb;
    for (int it = 0; it < 4; it++) begin
      mem_key = $urandom;
      db = AW'($urandom); wb = AW'($urandom); bb = AW'($urandom);
      rq = ND + NW + 3 + int'($urandom_range(0, 4));
      rv = rq + NB + 2 + int'($urandom_range(0, 4));
      ncyc = rv + 3;
      build_expect(db, wb, bb, mem_key, rq, rv);
      drive_pass(db, wb, bb, rq, rv, -1, -1, -1, ncyc);
      for (int c = 0; c < ncyc; c++) begin
        total++;
        if (tr_ctl[c] !== ex_ctl[c] || (ex_rd[c] && tr_ad[c] !== ex_ad[c])) begin
          bad++;
          $display("[TB] FAIL rnd%0d@%0d got ctl=%b addr=%h exp ctl=%b addr=%h",
                   it, c, tr_ctl[c], tr_ad[c], ex_ctl[c], ex_ad[c]);
        end
      end
      total++;
      if (abus.data !== ex_data || abus.weight !== ex_weight || abus.bias !== ex_bias) begin
        bad++;
        $display("[TB] FAIL rnd%0d_contents got d=%h w=%h b=%h exp d=%h w=%h b=%h",
                 it, abus.data, abus.weight, abus.bias, ex_data, ex_weight, ex_bias);
      end
    end
  endtask

  task automatic test_param_sweep;
    int nd, nw, nb, done_at, rq, rv;
    logic [ND2*32-1:0] ed;
    logic [NW2*32-1:0] ew;
    logic [NB2*32-1:0] eb;
    mem_key = $urandom;
    nd = 0; nw = 0; nb = 0; done_at = -1;
    rq = ND2 + NW2 + 3;
    rv = rq + NB2 + 2;
    for (int c = 0; c < rv + 3; c++) begin
      @(posedge clk); #1;
      b_start = (c == 0);
      b_db = 16'h100; b_wb = 16'h200; b_bb = 16'h300;
      bbus.bias_rq      = (c == rq);
      bbus.result_valid = (c == rv);
      @(negedge clk);
      if (bbus.mem_rd_en) begin
        if (bbus.mem_addr >= 16'h100 && bbus.mem_addr < 16'h100 + ND2) nd++;
        else if (bbus.mem_addr >= 16'h200 && bbus.mem_addr < 16'h200 + NW2) nw++;
        else if (bbus.mem_addr >= 16'h300 && bbus.mem_addr < 16'h300 + NB2) nb++;
      end
      if (b_done) done_at = c;
    end
    b_start = 1'b0; bbus.bias_rq = 1'b0; bbus.result_valid = 1'b0;
    for (int k = 0; k < ND2; k++) ed[k*32 +: 32] = mem_word(16'h100 + AW'(k), mem_key);
    for (int k = 0; k < NW2; k++) ew[k*32 +: 32] = mem_word(16'h200 + AW'(k), mem_key);
    for (int k = 0; k < NB2; k++) eb[k*32 +: 32] = mem_word(16'h300 + AW'(k), mem_key);
    total++;
    if (nd !== ND2 || nw !== NW2 || nb !== NB2) begin
      bad++;
      $display("[TB] FAIL sweep_counts got d=%0d w=%0d b=%0d exp %0d/%0d/%0d", nd, nw, nb, ND2, NW2, NB2);
    end
    total++;
    if (bbus.data[2*32 +: 32] !== mem_word(16'h102, mem_key) ||
        bbus.weight[5*32 +: 32] !== mem_word(16'h205, mem_key)) begin
      bad++;
      $display("[TB] FAIL sweep_corner got d10=%h w12=%h exp %h/%h", bbus.data[2*32 +: 32],
               bbus.weight[5*32 +: 32], mem_word(16'h102, mem_key), mem_word(16'h205, mem_key));
    end
    total++;
    if (bbus.data !== ed || bbus.weight !== ew || bbus.bias !== eb) begin
      bad++;
      $display("[TB] FAIL sweep_contents got d=%h b=%h exp d=%h b=%h", bbus.data, bbus.bias, ed, eb);
    end
    total++;
    if (done_at !== rv + 1) begin
      bad++;
      $display("[TB] FAIL sweep_done got=%0d exp=%0d", done_at, rv + 1);
    end
  endtask

  initial begin
    a_start = 1'b0; b_start = 1'b0;
    a_db = '0; a_wb = '0; a_bb = '0;
    b_db = '0; b_wb = '0; b_bb = '0;
    abus.bias_rq = 1'b0; abus.result_valid = 1'b0;
    bbus.bias_rq = 1'b0; bbus.result_valid = 1'b0;
    mem_key = 32'h0;
    test_reset;
    test_nominal;
    test_ignored_inputs;
    test_reset_mid;
    test_back_to_back;
    test_random;
    test_param_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_rd_ctrl.md
Name: fc_rd_ctrl

Overview:
- Read controller that feeds one fully-connected layer instance from a 32-bit word memory with a single read port.
- Fetches the data matrix and the weight matrix, then presents both together with a one-cycle data_en/weight_en pulse.
- Waits for the layer's bias_rq, then fetches the bias vector and holds bias_en until the layer reports result_valid.
- Sits between the on-chip parameter/activation memory and the FC datapath; sequences exactly one layer pass per start.

Parameters:
- batch_size, 1, rows of the data matrix.
- feature_size, 3, data columns = weight rows.
- bias_size, 2, weight columns = bias length.
- addr_width, 16, memory word-address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  begin one layer pass; sampled only in IDLE.
- data_base  in  addr_width  word address of data[0][0]; sampled with start.
- weight_base  in  addr_width  word address of weight[0][0]; sampled with start.
- bias_base  in  addr_width  word address of bias[0]; sampled with start.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  addr_width  read address.
- mem_rdata  in  32  read data; valid exactly 1 cycle after mem_rd_en.
- data  out  batch_size*feature_size*32  packed [batch][feature][32].
- weight  out  feature_size*bias_size*32  packed [feature][bias][32].
- bias  out  bias_size*32  packed [bias][32].
- data_en  out  1  data bus valid strobe.
- weight_en  out  1  weight bus valid strobe.
- bias_en  out  1  bias bus valid level.
- bias_rq  in  1  bias request pulse from the FC layer.
- result_valid  in  1  FC result strobe.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at the end of a pass.

Behaviour:
- Counts: ND = batch_size*feature_size, NW = feature_size*bias_size, NB = bias_size. Counters are sized $clog2(max+1).
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - mem_rd_en, data_en, weight_en, bias_en, busy and done go to 0.
  - mem_addr goes to 0.
  - data, weight and bias registers go to 0.
- States: IDLE, LOAD_DW, PRESENT_DW, WAIT_RQ, LOAD_B, HOLD_B, FINISH.
- IDLE:
  - On start=1, latch the three base addresses and go to LOAD_DW.
  - start is ignored in every other state.
- LOAD_DW:
  - Issue ND+NW back-to-back reads, one per cycle, mem_rd_en=1 throughout.
  - Read address order: data_base+k for k=0..ND-1, then weight_base+m for m=0..NW-1.
  - Word k lands in data[k/feature_size][k%feature_size].
  - Word m lands in weight[m/bias_size][m%bias_size].
  - Each word is captured the cycle after its read is issued.
  - After the last capture, go to PRESENT_DW.
- PRESENT_DW:
  - data_en=weight_en=1 for exactly one cycle, then go to WAIT_RQ.
  - data and weight stay stable until the next pass's LOAD_DW overwrites them.
- WAIT_RQ:
  - Wait for bias_rq=1, then go to LOAD_B.
  - A bias_rq seen in any other state is ignored.
- LOAD_B:
  - NB back-to-back reads at bias_base+c; word c lands in bias[c].
  - After the last capture, go to HOLD_B.
- HOLD_B:
  - bias_en=1 continuously, with bias stable.
  - On result_valid=1, drop bias_en in the next cycle and go to FINISH.
- FINISH:
  - done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- result_valid:
  - When it arrives in the same cycle as the last bias capture, it is not honoured.
  - It is honoured only in HOLD_B.
- mem_addr holds its last value when mem_rd_en=0.
- Reset mid-pass aborts immediately; there is no partial-output guarantee beyond the reset values.
- No timeout. The block waits forever in WAIT_RQ and HOLD_B.

Test Plan:
- Nominal pass (defaults; mem[a]=a; bases 0x10/0x20/0x30; start high in cycle 0):
  - Reads 0x10..0x12 in cycles 1–3 and 0x20..0x25 in cycles 4–9.
  - data_en=weight_en=1 only in cycle 11.
  - data = {0x12,0x11,0x10}; weight[2][1]=0x25, weight[0][0]=0x20.
- Bias phase: bias_rq pulse in cycle 14 -> reads 0x30, 0x31 in cycles 15–16.
  - bias_en=1 from cycle 18; bias[1]=0x31.
  - result_valid in cycle 25 -> bias_en=0 and done=1 in cycle 26; busy=0 in cycle 27.
- Ignored inputs:
  - start pulsed in cycle 5 causes no extra reads.
  - bias_rq pulsed in cycle 6 does not skip WAIT_RQ; bias reads occur only after a bias_rq in WAIT_RQ.
- Reset mid-pass: rst_n=0 during cycle 7 of LOAD_DW.
  - All outputs are 0 immediately and the state is IDLE.
  - A new start with bases 0x40/0x50/0x60 completes a clean pass with data = {0x42,0x41,0x40}.
- Back-to-back passes: start asserted in the cycle after done.
  - The second pass reuses no stale words.
  - data_en pulses exactly once per pass; done pulses exactly twice in total.
- Parameter sweep batch_size=2, feature_size=2, bias_size=3:
  - 4 data reads, 6 weight reads, 3 bias reads.
  - data[1][0]=data_base+2; weight[1][2]=weight_base+5.
